uart_tx_fifo_drain: RTL



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 27 ++
 rtl/uart_tx_fifo_drain.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, baud divisor and parity helpers.
// Reused by both the TX drain engine and the RX deserializer.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
    return (clk_freq + baud_rate / 2) / baud_rate;
  endfunction

  // Zero-extension does not change the XOR, so one wide argument serves every word size.
  function automatic logic calc_parity(input logic [63:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: emits a one-cycle tick every BAUD_DIV clocks, restartable by clr.
module uart_baud_gen #(
  parameter int BAUD_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(BAUD_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains the TX byte FIFO: pops a word whenever enabled and
// non-empty, then sends start, data LSB first, optional parity and stop bit(s).
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  frame_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
  localparam int BW       = $clog2(DATA_WIDTH + 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_fifo_drain: BAUD_DIV must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo_drain: STOP_BITS must be 1 or 2");
  end

  uart_state_e           state, state_d;
  logic [DATA_WIDTH-1:0] shift_reg, shift_d;
  logic [BW-1:0]         bit_cnt, bit_cnt_d;
  logic                  par_bit, par_d;
  logic                  tx_d, rd_d, done_d;
  logic                  tick;

  // Every non-IDLE transition happens on a tick, where the counter wraps to zero,
  // so holding clear in IDLE is enough to start each state on a full bit period.
  uart_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  // FIFO handshake: fifo_empty and fifo_data_in are sampled only in IDLE; a pop is
  // a single-cycle registered fifo_rd and the word is captured on that same edge,
  // so the FIFO head may change freely afterwards.
  always_comb begin
    state_d   = state;
    shift_d   = shift_reg;
    bit_cnt_d = bit_cnt;
    par_d     = par_bit;
    tx_d      = tx;
    rd_d      = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (enable && !fifo_empty) begin
          shift_d   = fifo_data_in;
          par_d     = calc_parity(64'(fifo_data_in), PARITY_ODD != 0);
          rd_d      = 1'b1;
          bit_cnt_d = '0;
          state_d   = START;
          tx_d      = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          tx_d      = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_reg >> 1;
          if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            tx_d      = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      shift_reg  <= shift_d;
      bit_cnt    <= bit_cnt_d;
      par_bit    <= par_d;
      tx         <= tx_d;
      fifo_rd    <= rd_d;
      tx_busy    <= (state_d != IDLE);
      frame_done <= done_d;
    end
  end

endmodule
